serial_addsub: RTL

Parametrised bit-serial adder/subtractor: loads two WIDTH-bit operands on a start handshake, processes one bit per clock LSB-first through a single full-adder cell and a carry flip-flop, and presents the registered result with a one-cycle done pulse. It is the next-generation serial arithmetic unit for area-constrained datapaths, adding width configuration, subtract mode and a start/busy/done handshake.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_addsub_full_adder.sv | 13 +
 rtl/serial_addsub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and mode constants for the bit-serial adder/subtractor
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// rtl/serial_addsub_full_adder.sv - single-bit full adder cell shared by every serial step
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - LSB-first bit-serial add/sub with start/busy/done handshake; SERIAL_ADDSUB_OVF_EN adds the ovf output
module serial_addsub
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic [WIDTH:0]   acc
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so after WIDTH steps bit 0 lands at position 0.
  assign res_next = (res_sr >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
  assign acc      = {cout, out};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; start is only honoured outside SHIFT
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand load, one full-adder step per SHIFT cycle, result capture on the last bit
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      out    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= data_a;
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            b_sr   <= (sub == MODE_SUB) ? ~data_b : data_b;
            carry  <= sub;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        SHIFT: begin
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            out  <= res_next;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Signed overflow: carry into the MSB cell differs from the carry out of it
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      ovf <= carry ^ fa_cout;
    end
  end
`endif

endmodule
